// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Two-port (CPU MEM stage / DMA loader) arbiter in front of a
//             single-port data memory with one-cycle read latency. The CPU
//             wins by default; a starved DMA port is forced through after
//             MAX_WAIT consecutive losing cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  // CPU MEM-stage port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  // DMA / loader port
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  // Single-port data memory
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_CPU = 2'd1,
    ST_RD_DMA = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_wait_cnt;
  logic       w_force_dma;
  logic       w_cpu_gnt;
  logic       w_dma_gnt;

  // Grant decision: CPU first unless the DMA port has starved long enough.
  // Reset masks every grant so nothing reaches the memory while held.
  always_comb begin
    w_force_dma = dma_req && (r_wait_cnt == c_max_wait);
    w_cpu_gnt   = !reset && cpu_req && !w_force_dma;
    w_dma_gnt   = !reset && dma_req && (w_force_dma || !cpu_req);
  end

  assign cpu_gnt   = w_cpu_gnt;
  assign dma_gnt   = w_dma_gnt;
  assign cpu_stall = !reset && cpu_req && !w_cpu_gnt;

  // Steer the granted port onto the memory bus; bus is all-zero when idle.
  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    if (w_cpu_gnt) begin
      mem_addr = cpu_addr;
      mem_din  = cpu_wdata;
      mem_we   = cpu_we;
      mem_re   = !cpu_we;
    end else if (w_dma_gnt) begin
      mem_addr = dma_addr;
      mem_din  = dma_wdata;
      mem_we   = dma_we;
      mem_re   = !dma_we;
    end
  end

  // DMA starvation counter: counts losing cycles, saturates, clears otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= 4'd0;
    end else if (dma_req && !w_dma_gnt) begin
      if (r_wait_cnt < c_max_wait) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
    end else begin
      r_wait_cnt <= 4'd0;
    end
  end

  // Read-in-flight state register; reset discards any pending return.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state depends only on this cycle's read grant, from any state.
  always_comb begin
    w_state_next = ST_IDLE;
    if (w_cpu_gnt && !cpu_we) begin
      w_state_next = ST_RD_CPU;
    end else if (w_dma_gnt && !dma_we) begin
      w_state_next = ST_RD_DMA;
    end
  end

  // Route returning memory data to the port that issued the read.
  always_comb begin
    cpu_rvalid = 1'b0;
    cpu_rdata  = '0;
    dma_rvalid = 1'b0;
    dma_rdata  = '0;
    case (r_state)
      ST_RD_CPU: begin
        cpu_rvalid = 1'b1;
        cpu_rdata  = mem_dout;
      end
      ST_RD_DMA: begin
        dma_rvalid = 1'b1;
        dma_rdata  = mem_dout;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Self-checking bench for dmem_arbiter with a memory model and a
//             cycle-level reference model of the arbitration rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  logic              clk;
  logic              reset;
  logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid, cpu_stall;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata, dma_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din, mem_dout;
  logic              mem_we, mem_re;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Memory model plus a backdoor loader used only while the DUT is idle.
  logic [DATA_W-1:0] mem [0:255];
  logic              bd_en;
  logic [7:0]        bd_addr;
  logic [DATA_W-1:0] bd_data;
  logic [DATA_W-1:0] ref_mem [0:255];

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_re(mem_re),
    .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: one-cycle read latency.
  always @(posedge clk) begin
    if (bd_en) mem[bd_addr] <= bd_data;
    else if (mem_we) mem[mem_addr[7:0]] <= mem_din;
    if (mem_re) mem_dout <= mem[mem_addr[7:0]];
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [DATA_W-1:0] d);
    bd_en = 1; bd_addr = a; bd_data = d;
    next_cycle();
    bd_en = 0;
  endtask

  task automatic test_reset;
    reset = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    dma_req = 1; dma_we = 1; dma_addr = 32'h20;
    @(negedge clk);
    total_cnt++; if (cpu_gnt !== 1'b0) $display("FAIL rst_cpu_gnt: got %b want 0", cpu_gnt); else pass_cnt++;
    total_cnt++; if (dma_gnt !== 1'b0) $display("FAIL rst_dma_gnt: got %b want 0", dma_gnt); else pass_cnt++;
    total_cnt++; if (cpu_stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", cpu_stall); else pass_cnt++;
    total_cnt++; if ({mem_we, mem_re} !== 2'b00) $display("FAIL rst_mem_en: got %b want 00", {mem_we, mem_re}); else pass_cnt++;
    total_cnt++; if ({cpu_rvalid, dma_rvalid} !== 2'b00) $display("FAIL rst_rvalid: got %b want 00", {cpu_rvalid, dma_rvalid}); else pass_cnt++;
    next_cycle();
    idle_inputs();
    preload(8'h10, 32'hDEADBEEF);
  endtask

  // Lone CPU read; also the first request seen after reset release.
  task automatic test_cpu_read;
    reset = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    @(negedge clk);
    total_cnt++; if ({cpu_gnt, mem_re} !== 2'b11) $display("FAIL cpurd_gnt_re: got %b want 11", {cpu_gnt, mem_re}); else pass_cnt++;
    total_cnt++; if (mem_addr !== 32'h10) $display("FAIL cpurd_addr: got %h want 00000010", mem_addr); else pass_cnt++;
    total_cnt++; if (cpu_stall !== 1'b0) $display("FAIL cpurd_stall0: got %b want 0", cpu_stall); else pass_cnt++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    total_cnt++; if (cpu_rvalid !== 1'b1) $display("FAIL cpurd_rvalid: got %b want 1", cpu_rvalid); else pass_cnt++;
    total_cnt++; if (cpu_rdata !== 32'hDEADBEEF) $display("FAIL cpurd_rdata: got %h want deadbeef", cpu_rdata); else pass_cnt++;
    total_cnt++; if (cpu_stall !== 1'b0) $display("FAIL cpurd_stall1: got %b want 0", cpu_stall); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_dma_write;
    dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'h12345678;
    @(negedge clk);
    total_cnt++; if ({dma_gnt, mem_we, mem_re} !== 3'b110) $display("FAIL dmawr_gnt_we: got %b want 110", {dma_gnt, mem_we, mem_re}); else pass_cnt++;
    total_cnt++; if (mem_din !== 32'h12345678) $display("FAIL dmawr_din: got %h want 12345678", mem_din); else pass_cnt++;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    total_cnt++; if (dma_rvalid !== 1'b0) $display("FAIL dmawr_no_rvalid: got %b want 0", dma_rvalid); else pass_cnt++;
    next_cycle();
    cpu_req = 1; cpu_addr = 32'h20;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    total_cnt++; if (cpu_rdata !== 32'h12345678 || cpu_rvalid !== 1'b1) $display("FAIL dmawr_readback: got %b/%h want 1/12345678", cpu_rvalid, cpu_rdata); else pass_cnt++;
    next_cycle();
  endtask

  // Both ports hammering: every fifth cycle goes to the DMA port.
  task automatic test_starvation;
    cpu_req = 1; cpu_addr = 32'h1;
    dma_req = 1; dma_addr = 32'h2;
    for (int i = 0; i < 10; i++) begin
      logic exp_dma;
      exp_dma = ((i % (MAX_WAIT + 1)) == MAX_WAIT);
      @(negedge clk);
      total_cnt++; if (dma_gnt !== exp_dma) $display("FAIL starve_dma_gnt[%0d]: got %b want %b", i, dma_gnt, exp_dma); else pass_cnt++;
      total_cnt++; if (cpu_gnt !== !exp_dma || cpu_stall !== exp_dma) $display("FAIL starve_cpu[%0d]: gnt/stall got %b%b want %b%b", i, cpu_gnt, cpu_stall, !exp_dma, exp_dma); else pass_cnt++;
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_back_to_back;
    logic [DATA_W-1:0] vals [4];
    vals[0] = 32'hA0A0_0003; vals[1] = 32'hB0B0_0004;
    vals[2] = 32'hC0C0_0005; vals[3] = 32'hD0D0_0006;
    for (int i = 0; i < 4; i++) preload(8'(i + 3), vals[i]);
    for (int k = 0; k < 5; k++) begin
      idle_inputs();
      if (k < 4) begin
        if (k % 2 == 0) begin cpu_req = 1; cpu_addr = 32'(k + 3); end
        else begin dma_req = 1; dma_addr = 32'(k + 3); end
      end
      @(negedge clk);
      if (k > 0) begin
        logic prev_cpu;
        prev_cpu = ((k - 1) % 2 == 0);
        total_cnt++; if (cpu_rvalid !== prev_cpu || dma_rvalid !== !prev_cpu) $display("FAIL b2b_rvalid[%0d]: got cpu%b dma%b want cpu%b dma%b", k, cpu_rvalid, dma_rvalid, prev_cpu, !prev_cpu); else pass_cnt++;
        total_cnt++; if ((prev_cpu ? cpu_rdata : dma_rdata) !== vals[k-1]) $display("FAIL b2b_rdata[%0d]: got %h want %h", k, prev_cpu ? cpu_rdata : dma_rdata, vals[k-1]); else pass_cnt++;
      end
      if (k < 4) begin
        total_cnt++; if ((cpu_gnt | dma_gnt) !== 1'b1) $display("FAIL b2b_gnt[%0d]: got %b%b want one grant", k, cpu_gnt, dma_gnt); else pass_cnt++;
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_inflight;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    @(negedge clk);
    total_cnt++; if (cpu_gnt !== 1'b1) $display("FAIL rstfl_gnt: got %b want 1", cpu_gnt); else pass_cnt++;
    #1 reset = 1;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    total_cnt++; if (cpu_rvalid !== 1'b0) $display("FAIL rstfl_rvalid_in_rst: got %b want 0", cpu_rvalid); else pass_cnt++;
    next_cycle();
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total_cnt++; if ({cpu_rvalid, dma_rvalid} !== 2'b00) $display("FAIL rstfl_rvalid_after[%0d]: got %b want 00", i, {cpu_rvalid, dma_rvalid}); else pass_cnt++;
      next_cycle();
    end
  endtask

  // DMA gives up after 3 losses; the starvation count must start over.
  task automatic test_wait_restart;
    cpu_req = 1; cpu_addr = 32'h1;
    for (int i = 0; i < 9; i++) begin
      logic exp_dma;
      dma_req = (i != 3); dma_addr = 32'h2;
      exp_dma = (i == 8);
      @(negedge clk);
      total_cnt++; if (dma_gnt !== exp_dma) $display("FAIL restart_dma_gnt[%0d]: got %b want %b", i, dma_gnt, exp_dma); else pass_cnt++;
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  // Random traffic checked against a per-cycle model of the arbitration rules.
  task automatic test_random;
    int                streak, pend;
    logic [DATA_W-1:0] pend_data, exp_din;
    logic [ADDR_W-1:0] exp_addr;
    logic              forced, ecg, edg, exp_we, exp_re, cpu_hold, dma_hold;
    for (int i = 0; i < 16; i++) begin
      logic [DATA_W-1:0] v;
      v = $urandom;
      ref_mem[i] = v;
      preload(8'(i), v);
    end
    streak = 0; pend = 0; pend_data = '0; cpu_hold = 0; dma_hold = 0;
    for (int n = 0; n < 400; n++) begin
      if (!cpu_hold) begin
        cpu_req = ($urandom_range(0, 9) < 6); cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 32'($urandom_range(0, 15)); cpu_wdata = $urandom;
      end
      if (!dma_hold) begin
        dma_req = ($urandom_range(0, 9) < 5); dma_we = 1'($urandom_range(0, 1));
        dma_addr = 32'($urandom_range(0, 15)); dma_wdata = $urandom;
      end
      @(negedge clk);
      forced = dma_req && (streak == MAX_WAIT);
      ecg = cpu_req && !forced;
      edg = dma_req && !ecg;
      exp_addr = ecg ? cpu_addr : (edg ? dma_addr : '0);
      exp_din  = ecg ? cpu_wdata : (edg ? dma_wdata : '0);
      exp_we   = (ecg && cpu_we) || (edg && dma_we);
      exp_re   = (ecg && !cpu_we) || (edg && !dma_we);
      total_cnt++; if ({cpu_gnt, dma_gnt, cpu_stall} !== {ecg, edg, cpu_req && !ecg}) $display("FAIL rnd_gnt[%0d]: got %b%b%b want %b%b%b", n, cpu_gnt, dma_gnt, cpu_stall, ecg, edg, cpu_req && !ecg); else pass_cnt++;
      total_cnt++; if ({mem_we, mem_re} !== {exp_we, exp_re} || mem_addr !== exp_addr || mem_din !== exp_din) $display("FAIL rnd_bus[%0d]: got %b%b %h %h want %b%b %h %h", n, mem_we, mem_re, mem_addr, mem_din, exp_we, exp_re, exp_addr, exp_din); else pass_cnt++;
      total_cnt++; if ({cpu_rvalid, dma_rvalid} !== {pend == 1, pend == 2}) $display("FAIL rnd_rvalid[%0d]: got %b%b want %b%b", n, cpu_rvalid, dma_rvalid, pend == 1, pend == 2); else pass_cnt++;
      total_cnt++; if (cpu_rdata !== (pend == 1 ? pend_data : '0) || dma_rdata !== (pend == 2 ? pend_data : '0)) $display("FAIL rnd_rdata[%0d]: got %h %h pend %0d want %h", n, cpu_rdata, dma_rdata, pend, pend_data); else pass_cnt++;
      pend = 0;
      if (ecg) begin
        if (cpu_we) ref_mem[cpu_addr[7:0]] = cpu_wdata;
        else begin pend = 1; pend_data = ref_mem[cpu_addr[7:0]]; end
      end else if (edg) begin
        if (dma_we) ref_mem[dma_addr[7:0]] = dma_wdata;
        else begin pend = 2; pend_data = ref_mem[dma_addr[7:0]]; end
      end
      if (dma_req && !edg) streak = (streak < MAX_WAIT) ? streak + 1 : MAX_WAIT;
      else streak = 0;
      cpu_hold = cpu_req && !ecg;
      dma_hold = dma_req && !edg;
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    bd_en = 0; bd_addr = '0; bd_data = '0;
    idle_inputs();
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_starvation();
    test_back_to_back();
    test_reset_inflight();
    test_wait_restart();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter MAX_WAIT, default 4, consecutive losing cycles before the DMA port is forced a grant (range 1..15).
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports cpu_req, cpu_we (input, 1), cpu_addr (input, ADDR_W) and cpu_wdata (input, DATA_W): MEM-stage request, write enable, address and write data.
REQ-007 SHALL have outputs cpu_gnt, cpu_rvalid, cpu_stall (1) and cpu_rdata (DATA_W): grant, read-data valid, pipeline stall and read data.
REQ-008 SHALL have ports dma_req, dma_we (input, 1), dma_addr (input, ADDR_W), dma_wdata (input, DATA_W), dma_gnt, dma_rvalid (output, 1) and dma_rdata (output, DATA_W): the same set for the loader/DMA port.
REQ-009 SHALL have outputs mem_addr (ADDR_W), mem_din (DATA_W), mem_we and mem_re (1), and input mem_dout (DATA_W), all to/from the single-port data memory; read data is valid one cycle after mem_re.

Function
REQ-010 Grant SHALL be combinational in the request cycle; at most one of cpu_gnt/dma_gnt is high per cycle.
REQ-011 Default priority: CPU wins when both ports request.
REQ-012 wait_cnt (4 bit) SHALL increment each cycle dma_req=1 and dma_gnt=0, clear on any dma_gnt or when dma_req=0, and saturate at MAX_WAIT.
REQ-013 When wait_cnt==MAX_WAIT and dma_req=1, DMA SHALL be granted regardless of cpu_req.
REQ-014 A granted port SHALL drive mem_addr/mem_din; mem_we=gnt&we; mem_re=gnt&~we. With no grant: mem_we=mem_re=0 and mem_addr/mem_din=0.
REQ-015 cpu_stall SHALL equal cpu_req & ~cpu_gnt.
REQ-016 Writes complete in the grant cycle; no rvalid is produced for a write.
REQ-017 A 2-bit FSM tracks the read in flight: IDLE, RD_CPU, RD_DMA. On any edge it SHALL go to RD_CPU if a CPU read is granted, to RD_DMA if a DMA read is granted, else to IDLE; this holds from any state.
REQ-018 In RD_CPU: cpu_rvalid=1 and cpu_rdata=mem_dout. In RD_DMA: dma_rvalid=1 and dma_rdata=mem_dout. Otherwise rvalid=0 and rdata=0.
REQ-019 Back-to-back reads SHALL be supported: a new grant is issued in the same cycle the previous read returns data (throughput 1 access/cycle).
REQ-020 A requester SHALL hold req/we/addr/wdata stable until granted; the arbiter does not latch request fields.
REQ-021 Simultaneous CPU write and DMA read with wait_cnt<MAX_WAIT SHALL grant the CPU write; the DMA read is granted the next cycle the CPU does not request, or when forced.

Reset
REQ-022 While reset=1: FSM=IDLE, wait_cnt=0, and all gnt, rvalid, stall, mem_we and mem_re outputs are 0 regardless of requests.
REQ-023 Reset asserted while a read is in flight SHALL discard it: no rvalid is produced after reset deasserts.
REQ-024 First grant after reset deassertion SHALL occur in the first cycle a request is seen with reset=0.

Verification
REQ-025 Lone CPU read, addr 0x10 (memory holds 0xDEADBEEF) -> cpu_gnt and mem_re high in cycle 0; cpu_rvalid=1 with cpu_rdata=0xDEADBEEF in cycle 1; cpu_stall never high.
REQ-026 Lone DMA write, addr 0x20, data 0x12345678 -> dma_gnt=1 and mem_we=1 in the same cycle; a subsequent CPU read of 0x20 returns 0x12345678.
REQ-027 Both ports continuously requesting, MAX_WAIT=4 -> CPU granted for 4 cycles, DMA granted in cycle 4 with cpu_stall=1 there, wait_cnt back to 0, then the pattern repeats.
REQ-028 Alternating CPU read and DMA read on consecutive cycles -> rvalid appears on the correct port one cycle after each grant; no cycle has both rvalid high.
REQ-029 Reset asserted the cycle after a CPU read grant -> cpu_rvalid stays 0; the FSM reads IDLE after release.
REQ-030 DMA drops dma_req at wait_cnt=3, then re-requests -> wait_cnt restarts from 0, and a forced grant occurs only after 4 further losing cycles.
